// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit common-anode 7-seg driver with hex decode; ports clk/rst, value/dp_in/digit_en/load in, seg/dp/anode/slot_tick out (all active-low except slot_tick); optional LEADING_ZERO_BLANK_EN
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    slot_tick
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [111:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  typedef enum logic {BLANK, DRIVE} state_t;
  localparam state_t SLOT_START = BLANK_CYCLES == 0 ? DRIVE : BLANK;
  state_t                  st_q, st_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, ds_val_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q, ds_dp_q, ds_en_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d, tick_q, wrap, lz, show;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  always_comb begin
    wrap    = cnt_q == CW'(REFRESH_CYCLES - 1);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = !wrap ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
    st_d    = wrap ? SLOT_START : (st_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1)) ? DRIVE : st_q;
    nib     = ds_val_q[4*int'(idx_q) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz      = idx_q != '0 && (ds_val_q >> (4*int'(idx_q))) == '0;
`else
    lz      = 1'b0;
`endif
    show    = st_q == DRIVE && ds_en_q[idx_q] && !lz;
    seg_d   = show ? HEX[7*int'(nib) +: 7] : 7'h7F;
    dp_d    = show ? ~ds_dp_q[idx_q] : 1'b1;
    anode_d = show ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= SLOT_START;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      ds_val_q <= '0;
      ds_dp_q  <= '0;
      ds_en_q  <= '0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      anode_q  <= '1;
      tick_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      anode_q <= anode_d;
      tick_q  <= wrap;
      if (load) begin
        sh_val_q <= value;
        sh_dp_q  <= dp_in;
        sh_en_q  <= digit_en;
      end
      if (wrap) begin
        ds_val_q <= sh_val_q;
        ds_dp_q  <= sh_dp_q;
        ds_en_q  <= sh_en_q;
      end
    end
  end
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign anode     = anode_q;
  assign slot_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: self-checking bench for seven_seg_scan_driver with a time-indexed reference model
module tb_seven_seg_scan_driver;
  localparam int N = 4, R = 4, B = 1;
  logic clk = 0, rst = 1, load = 0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, digit_en = '0;
  logic [6:0] seg;
  logic dp, slot_tick;
  logic [3:0] anode;
  int errors = 0, checks = 0;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en), .load(load),
    .seg(seg), .dp(dp), .anode(anode), .slot_tick(slot_tick));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: slot position and digit come from elapsed cycles since reset.
  logic [6:0] hext [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int t, p, di;
  bit valid = 0, on, lzb;
  logic [15:0] m_sh_v, m_ds_v;
  logic [3:0] m_sh_dp, m_sh_en, m_ds_dp, m_ds_en, e_an;
  logic [6:0] e_seg;
  logic e_dp, e_tick;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_sh_v = 0; m_ds_v = 0; m_sh_dp = 0; m_sh_en = 0; m_ds_dp = 0; m_ds_en = 0;
      e_seg = 7'h7F; e_dp = 1; e_an = 4'hF; e_tick = 0; valid = 1;
    end else begin
      p = t % R;
      di = (t / R) % N;
`ifdef LEADING_ZERO_BLANK_EN
      lzb = di != 0 && (m_ds_v >> (4*di)) == 0;
`else
      lzb = 0;
`endif
      on = p >= B && m_ds_en[di] && !lzb;
      e_seg = on ? hext[m_ds_v[4*di +: 4]] : 7'h7F;
      e_dp = on ? ~m_ds_dp[di] : 1'b1;
      e_an = on ? ~(4'b1 << di) : 4'hF;
      e_tick = p == R - 1;
      if (p == R - 1) begin
        m_ds_v = m_sh_v; m_ds_dp = m_sh_dp; m_ds_en = m_sh_en;
      end
      if (load) begin
        m_sh_v = value; m_sh_dp = dp_in; m_sh_en = digit_en;
      end
      t++;
    end
  end

  always @(negedge clk) if (valid) begin
    chk("model seg", seg, e_seg);
    chk("model dp", dp, e_dp);
    chk("model anode", anode, e_an);
    chk("model slot_tick", slot_tick, e_tick);
  end

  task automatic wait_anode(input logic [3:0] a, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (anode != a && n < 64);
    chk(nm, anode, a);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin @(negedge clk); n++; end while (!slot_tick && n < 64);
    chk("tick wait", slot_tick, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
    value = v; digit_en = en; dp_in = d; load = 1;
    @(negedge clk);
    load = 0;
  endtask

  logic [3:0] lit_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] lit_sg [4] = '{7'h00, 7'h08, 7'h24, 7'h79};
  int cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset seg", seg, 7'h7F);
    chk("reset anode", anode, 4'hF);
    chk("reset dp", dp, 1);
    chk("reset tick", slot_tick, 0);
    rst = 0;
    do_load(16'h12A8, 4'hF, 4'h0);
    wait_anode(4'hE, "first digit0");
    for (int i = 0; i < 16; i++) begin
      if (i % 4 < 3) begin
        chk("scan anode", anode, lit_an[i/4]);
        chk("scan seg", seg, lit_sg[i/4]);
        chk("scan tick", slot_tick, i % 4 == 2);
      end else begin
        chk("blank anode", anode, 4'hF);
        chk("blank seg", seg, 7'h7F);
      end
      @(negedge clk);
    end
    do_load(16'h12A8, 4'b0101, 4'b0001);
    repeat (12) @(negedge clk);
    wait_anode(4'hE, "en digit0");
    chk("dp digit0", dp, 0);
    wait_anode(4'hB, "en digit2");
    chk("dp digit2", dp, 1);
    chk("seg digit2", seg, 7'h24);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode == 4'hD || anode == 4'h7) cnt++;
    end
    chk("disabled digits dark", cnt, 0);
    do_load(16'h12A8, 4'hF, 4'h0);
    repeat (16) @(negedge clk);
    wait_anode(4'hD, "tear digit1");
    do_load(16'h3456, 4'hF, 4'h0);
    chk("no tear seg", seg, 7'h08);
    wait_anode(4'hB, "new digit2");
    chk("new content seg", seg, 7'h19);
    wait_tick();
    do_load(16'h9BCD, 4'hF, 4'hF);
    repeat (10) @(negedge clk);
    wait_tick();
    repeat (2) @(negedge clk);
    do_load(16'hE0F7, 4'hF, 4'h2);
    repeat (20) @(negedge clk);
    wait_anode(4'hB, "pre-reset digit2");
    rst = 1;
    @(negedge clk);
    chk("mid reset anode", anode, 4'hF);
    chk("mid reset seg", seg, 7'h7F);
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode != 4'hF) cnt++;
    end
    chk("shadow cleared", cnt, 0);
    do_load(16'h0070, 4'hF, 4'h0);
    repeat (20) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode == 4'hB || anode == 4'h7) cnt++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz 0070 upper dark", cnt, 0);
`else
    chk("lz 0070 upper shown", cnt, 6);
`endif
    do_load(16'h0000, 4'hF, 4'h0);
    repeat (20) @(negedge clk);
    wait_anode(4'hE, "zero digit0");
    chk("zero seg", seg, 7'h40);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (anode != 4'hF && anode != 4'hE) cnt++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    chk("zero upper dark", cnt, 0);
`else
    chk("zero upper shown", cnt, 9);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
